// File: rtl/fma_unit_arb.sv
// Shared-unit arbiter and result router: one-hot grant with optional multi-cycle lock, LAT-deep tag pipe.
// Build option FMA_ARB_RR_EN selects round-robin arbitration; undefined gives lowest-index-first priority.
module fma_unit_arb #(
  parameter int NCLI = 3,
  parameter int DW   = 80,
  parameter int RW   = 82,
  parameter int LAT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCLI-1:0]    cli_req,
  input  logic [NCLI-1:0]    cli_lock,
  input  logic [NCLI*DW-1:0] cli_data,
  output logic [NCLI-1:0]    cli_gnt,
  output logic [NCLI-1:0]    cli_vld,
  output logic [RW-1:0]      cli_rslt,
  output logic               unit_en,
  output logic [DW-1:0]      unit_in,
  input  logic [RW-1:0]      unit_out
);

  localparam int IW = $clog2(NCLI);

  logic                   lock_vld_q;
  logic                   lock_vld_d;
  logic [IW-1:0]          lock_idx_q;
  logic [IW-1:0]          lock_idx_d;
  logic [NCLI-1:0]        tag_q [LAT];
  logic [NCLI-1:0]        tag_d [LAT];

  logic                   lock_hit;
  logic                   found;
  logic [IW-1:0]          cand;
  logic [NCLI-1:0]        arb_gnt;
  logic                   gnt_any;
  logic [IW-1:0]          gnt_idx;
  logic [NCLI-1:0][DW-1:0] data_masked;

`ifdef FMA_ARB_RR_EN
  logic [IW-1:0]          ptr_q;
  logic [IW-1:0]          ptr_d;

  // Client index base+off, wrapped into 0..NCLI-1 (NCLI need not be a power of two).
  function automatic logic [IW-1:0] rr_cand(input logic [IW-1:0] base, input logic [IW-1:0] off);
    logic [IW:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (IW+1)'(NCLI)) begin
      sum = sum - (IW+1)'(NCLI);
    end else begin
      sum = sum;
    end
    return sum[IW-1:0];
  endfunction
`endif

  // Grant selection: a live lock wins outright, otherwise first requester in search order.
  always_comb begin
    lock_hit = lock_vld_q & cli_req[lock_idx_q];
    arb_gnt  = '0;
    found    = 1'b0;
    cand     = '0;
    if (lock_hit) begin
      arb_gnt[lock_idx_q] = 1'b1;
    end else begin
      for (int i = 0; i < NCLI; i++) begin
`ifdef FMA_ARB_RR_EN
        cand = rr_cand(ptr_q, IW'(i));
`else
        cand = IW'(i);
`endif
        if (!found && cli_req[cand]) begin
          arb_gnt[cand] = 1'b1;
          found         = 1'b1;
        end else begin
          found = found;
        end
      end
    end
  end

  // Grants are suppressed while reset is held.
  always_comb begin
    if (reset) begin
      cli_gnt = '0;
    end else begin
      cli_gnt = arb_gnt;
    end
  end

  // Granted index and the payload it forwards.
  always_comb begin
    gnt_any = |cli_gnt;
    gnt_idx = '0;
    unit_in = '0;
    for (int i = 0; i < NCLI; i++) begin
      gnt_idx = gnt_idx | ({IW{cli_gnt[IW'(i)]}} & IW'(i));
      unit_in = unit_in | data_masked[IW'(i)];
    end
  end

  for (genvar g = 0; g < NCLI; g++) begin : g_mask
    assign data_masked[g] = cli_data[g*DW +: DW] & {DW{cli_gnt[g]}};
  end

  assign unit_en  = gnt_any;
  assign cli_rslt = unit_out;
  assign cli_vld  = tag_q[LAT-1];

  // Lock follows the current grant; any cycle without a locking grant drops it.
  always_comb begin
    lock_vld_d = gnt_any & cli_lock[gnt_idx];
    if (gnt_any) begin
      lock_idx_d = gnt_idx;
    end else begin
      lock_idx_d = lock_idx_q;
    end
  end

  assign tag_d[0] = cli_gnt;
  for (genvar g = 1; g < LAT; g++) begin : g_tag
    assign tag_d[g] = tag_q[g-1];
  end

  // Lock owner and tag pipeline state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      tag_q      <= '{default: '0};
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      tag_q      <= tag_d;
    end
  end

`ifdef FMA_ARB_RR_EN
  // Pointer advances past the winner only on arbitrated grants; locked grants leave it.
  always_comb begin
    if (gnt_any && !lock_hit) begin
      if (gnt_idx == IW'(NCLI-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + IW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_fma_unit_arb.sv
// Directed bench for fma_unit_arb (NCLI=3, LAT=2); expectations follow the FMA_ARB_RR_EN build setting.
module tb_fma_unit_arb;

  localparam int NCLI = 3;
  localparam int DW   = 80;
  localparam int RW   = 82;
  localparam int LAT  = 2;
`ifdef FMA_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [79:0] D0 = 80'hA0A0_1111_2222_3333_4444;
  localparam logic [79:0] D1 = 80'hB1B1_5555_6666_7777_8888;
  localparam logic [79:0] D2 = 80'hC2C2_9999_AAAA_BBBB_CCCC;

  logic               clk;
  logic               reset;
  logic [NCLI-1:0]    cli_req;
  logic [NCLI-1:0]    cli_lock;
  logic [NCLI*DW-1:0] cli_data;
  logic [NCLI-1:0]    cli_gnt;
  logic [NCLI-1:0]    cli_vld;
  logic [RW-1:0]      cli_rslt;
  logic               unit_en;
  logic [DW-1:0]      unit_in;
  logic [RW-1:0]      unit_out;

  int          n_vec;
  int          n_err;
  int          cyc;
  logic [2:0]  exp_p1;
  logic [2:0]  exp_p2;
  logic [95:0] rnd;

  assign cli_data = {D2, D1, D0};

  fma_unit_arb #(.NCLI(NCLI), .DW(DW), .RW(RW), .LAT(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .cli_req  (cli_req),
    .cli_lock (cli_lock),
    .cli_data (cli_data),
    .cli_gnt  (cli_gnt),
    .cli_vld  (cli_vld),
    .cli_rslt (cli_rslt),
    .unit_en  (unit_en),
    .unit_in  (unit_in),
    .unit_out (unit_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, then age the expected-grant history.
  task automatic apply(input logic r, input logic [2:0] req, input logic [2:0] lock,
                       input logic [2:0] e_rr, input logic [2:0] e_fx);
    logic [2:0]  e;
    logic [79:0] e_in;
    e = RR ? e_rr : e_fx;
    if (r) begin
      e      = 3'b000;
      exp_p1 = 3'b000;
      exp_p2 = 3'b000;
    end
    reset    = r;
    cli_req  = req;
    cli_lock = lock;
    rnd      = {$urandom, $urandom, $urandom};
    unit_out = rnd[81:0];
    case (e)
      3'b001:  e_in = D0;
      3'b010:  e_in = D1;
      3'b100:  e_in = D2;
      default: e_in = 80'h0;
    endcase
    @(negedge clk);
    check_val($sformatf("gnt@%0d", cyc), {125'h0, cli_gnt}, {125'h0, e});
    check_val($sformatf("en@%0d", cyc), {127'h0, unit_en}, {127'h0, |e});
    check_val($sformatf("in@%0d", cyc), {48'h0, unit_in}, {48'h0, e_in});
    check_val($sformatf("vld@%0d", cyc), {125'h0, cli_vld}, {125'h0, exp_p2});
    check_val($sformatf("rslt@%0d", cyc), {46'h0, cli_rslt}, {46'h0, unit_out});
    @(posedge clk);
    #1;
    exp_p2 = exp_p1;
    exp_p1 = e;
    cyc++;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    cyc    = 0;
    exp_p1 = 3'b000;
    exp_p2 = 3'b000;

    // Reset with everyone requesting: grants gated off.
    apply(1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
    apply(1'b1, 3'b111, 3'b000, 3'b000, 3'b000);

    // All clients requesting for six cycles.
    apply(1'b0, 3'b111, 3'b000, 3'b001, 3'b001);
    apply(1'b0, 3'b111, 3'b000, 3'b010, 3'b001);
    apply(1'b0, 3'b111, 3'b000, 3'b100, 3'b001);
    apply(1'b0, 3'b111, 3'b000, 3'b001, 3'b001);
    apply(1'b0, 3'b111, 3'b000, 3'b010, 3'b001);
    apply(1'b0, 3'b111, 3'b000, 3'b100, 3'b001);
    apply(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
    apply(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);

    // Client 1 locks for three cycles, releases on the fourth; client 0 waits.
    apply(1'b0, 3'b010, 3'b010, 3'b010, 3'b010);
    apply(1'b0, 3'b011, 3'b010, 3'b010, 3'b010);
    apply(1'b0, 3'b011, 3'b010, 3'b010, 3'b010);
    apply(1'b0, 3'b011, 3'b000, 3'b010, 3'b010);
    apply(1'b0, 3'b001, 3'b010, 3'b001, 3'b001);
    apply(1'b0, 3'b011, 3'b000, 3'b010, 3'b001);

    // Lock holder drops its request: client 2 wins that cycle, lock gone afterwards.
    apply(1'b0, 3'b010, 3'b010, 3'b010, 3'b010);
    apply(1'b0, 3'b110, 3'b010, 3'b010, 3'b010);
    apply(1'b0, 3'b100, 3'b000, 3'b100, 3'b100);
    apply(1'b0, 3'b111, 3'b000, 3'b001, 3'b001);

    // Sparse requests with idle gaps.
    apply(1'b0, 3'b001, 3'b000, 3'b001, 3'b001);
    apply(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
    apply(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
    apply(1'b0, 3'b001, 3'b000, 3'b001, 3'b001);
    apply(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
    apply(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);

    // Reset one cycle after a grant: the in-flight result is discarded, pointer restarts.
    apply(1'b0, 3'b010, 3'b000, 3'b010, 3'b010);
    apply(1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
    apply(1'b0, 3'b111, 3'b000, 3'b001, 3'b001);
    apply(1'b0, 3'b111, 3'b000, 3'b010, 3'b001);

    // Clients 1 and 2 contending.
    apply(1'b0, 3'b110, 3'b000, 3'b100, 3'b010);
    apply(1'b0, 3'b110, 3'b000, 3'b010, 3'b010);
    apply(1'b0, 3'b110, 3'b000, 3'b100, 3'b010);
    apply(1'b0, 3'b110, 3'b000, 3'b010, 3'b010);
    apply(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
    apply(1'b0, 3'b000, 3'b000, 3'b000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
